// File: rtl/uart_tx_ctrl.sv
// UART transmitter sequencer: frames a byte as start + 8 data (LSB first) + stop,
// taking each bit period from an external registered bit-timing ROM.
module uart_tx_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [3:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        FETCH,
        BIT
    } state_t;

    state_t           state_q;
    logic [3:0]       bit_idx_q;
    logic [WIDTH-1:0] cnt_q;
    logic [7:0]       shreg_q;
    logic             tx_out_q;
    logic             done_q;

    logic [WIDTH-1:0] cnt_d;
    logic             next_bit_d;
    logic             done_d;

    // ADDR and FETCH already spend two cycles of the bit, so the BIT countdown
    // is loaded with max(rom_data,3)-3; clamping keeps short periods from wrapping.
    always_comb begin
        cnt_d = '0;
        if (rom_data > WIDTH'(3)) begin
            cnt_d = rom_data - WIDTH'(3);
        end
        next_bit_d = 1'b1;
        if (bit_idx_q < 4'd8) begin
            next_bit_d = shreg_q[bit_idx_q[2:0]];
        end
        // frame_done is registered, so it is raised on the edge entering the final stop cycle
        done_d = 1'b0;
        if (bit_idx_q == 4'd9) begin
            if (state_q == FETCH && cnt_d == '0) begin
                done_d = 1'b1;
            end else if (state_q == BIT && cnt_q == WIDTH'(1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            tx_out_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_d;
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shreg_q   <= tx_data;
                        bit_idx_q <= '0;
                        tx_out_q  <= 1'b0;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    cnt_q   <= cnt_d;
                    state_q <= BIT;
                end
                BIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - WIDTH'(1);
                    end else if (bit_idx_q == 4'd9) begin
                        tx_out_q <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                        tx_out_q  <= next_bit_d;
                        state_q   <= ADDR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rom_addr   = bit_idx_q;
    assign tx_out     = tx_out_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a per-bit duration model checked every cycle, plus
// directed frames with hand-computed timings and line values.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    logic [7:0] rom_tab [10];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.WIDTH(8)) dut (
        .CLOCK      (clk),
        .RESET      (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Registered ROM: data appears one cycle after the address is sampled.
    always @(posedge clk) begin
        if (rom_addr < 4'd10) rom_data <= rom_tab[rom_addr];
        else                  rom_data <= '0;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dur(input int i);
        return (rom_tab[i] < 8'd3) ? 3 : int'(rom_tab[i]);
    endfunction

    // Model: a frame is ten bit values, each held for dur(index) cycles.
    bit m_busy = 1'b0;
    bit m_line = 1'b1;
    bit m_done = 1'b0;
    bit m_bits [10];
    int m_idx  = 0;
    int m_rem  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_line = 1'b1; m_done = 1'b0; m_idx = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (tx_valid) begin
                m_bits[0] = 1'b0;
                for (int i = 1; i <= 8; i++) m_bits[i] = tx_data[i-1];
                m_bits[9] = 1'b1;
                m_idx = 0; m_rem = dur(0); m_line = 1'b0; m_busy = 1'b1;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_idx == 9) begin
                    m_busy = 1'b0; m_line = 1'b1;
                end else begin
                    m_idx++; m_rem = dur(m_idx); m_line = m_bits[m_idx];
                end
            end
            m_done = m_busy && m_idx == 9 && m_rem == 1;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("model tx_out", int'(tx_out), int'(m_line));
            check("model busy", int'(busy), int'(m_busy));
            check("model tx_ready", int'(tx_ready), int'(!m_busy));
            check("model frame_done", int'(frame_done), int'(m_done));
            if (m_busy) check("model rom_addr", int'(rom_addr), m_idx);
        end
    end

    bit cap_en = 1'b0;
    bit cap [$];
    int done_cnt = 0;
    always @(negedge clk) begin
        if (cap_en && busy)       cap.push_back(tx_out);
        if (cap_en && frame_done) done_cnt++;
    end

    task automatic start_cap();
        cap.delete();
        done_cnt = 0;
        cap_en   = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, int'(busy), 0);
    endtask

    task automatic set_rom(input int v);
        for (int i = 0; i < 10; i++) rom_tab[i] = 8'(v);
    endtask

    int  d_lit [10] = '{169, 169, 169, 169, 169, 168, 169, 169, 169, 169};
    bit  b_lit [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    bit  b96   [10] = '{0, 0, 1, 1, 0, 1, 0, 0, 1, 1};
    int  s;
    int  gap;

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
        set_rom(169);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset tx_ready", int'(tx_ready), 1);
        check("reset busy", int'(busy), 0);
        check("reset tx_out", int'(tx_out), 1);
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset frame_done", int'(frame_done), 0);
        rst = 1'b0;

        // 0xA5 with ROM = 168 + bit(0x3DF)
        for (int i = 0; i < 10; i++) rom_tab[i] = (i == 5) ? 8'd168 : 8'd169;
        start_cap();
        send(8'hA5);
        wait_idle(3000, "A5 timeout");
        check("A5 frame length", cap.size(), 1689);
        check("A5 frame_done count", done_cnt, 1);
        s = 0;
        for (int k = 0; k < 10; k++) begin
            if (s + d_lit[k] / 2 < cap.size())
                check($sformatf("A5 bit%0d", k), int'(cap[s + d_lit[k] / 2]), int'(b_lit[k]));
            else
                check($sformatf("A5 bit%0d missing", k), 0, 1);
            if (s > 0 && s < cap.size())
                check($sformatf("A5 edge%0d", k), int'(cap[s]), int'(b_lit[k]));
            s += d_lit[k];
        end

        // ROM returns 0: every bit clamps to 3 cycles
        set_rom(0);
        start_cap();
        send(8'h5A);
        wait_idle(100, "zero timeout");
        check("zero frame length", cap.size(), 30);
        check("zero frame_done count", done_cnt, 1);

        // Mixed sub-3 and small values: 3,3,3,3,4,3,3,3,3,5
        rom_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2, 8'd3, 8'd5};
        start_cap();
        send(8'hC3);
        wait_idle(100, "clamp timeout");
        check("clamp frame length", cap.size(), 33);

        // Back-to-back with tx_valid held: one idle cycle between frames
        set_rom(0);
        start_cap();
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h00;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!frame_done && gap < 100);
        check("b2b first done seen", int'(frame_done), 1);
        tx_data = 8'hFF;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (tx_out && gap < 10);
        check("b2b done-to-start gap", gap, 2);
        tx_valid = 1'b0;
        wait_idle(100, "b2b timeout");
        check("b2b frame_done count", done_cnt, 2);
        check("b2b total busy", cap.size(), 60);

        // tx_valid pulse while busy is ignored
        set_rom(10);
        start_cap();
        send(8'h96);
        repeat (35) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h3C;
        check("busy tx_ready", int'(tx_ready), 0);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle(200, "ignore timeout");
        check("ignore frame length", cap.size(), 100);
        for (int k = 0; k < 10; k++)
            if (k * 10 + 5 < cap.size())
                check($sformatf("96 bit%0d", k), int'(cap[k * 10 + 5]), int'(b96[k]));
        @(negedge clk);
        check("ignore no second frame", int'(busy), 0);

        // Reset mid-frame
        for (int i = 0; i < 10; i++) rom_tab[i] = (i == 5) ? 8'd168 : 8'd169;
        start_cap();
        send(8'h55);
        repeat (498) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort tx_out", int'(tx_out), 1);
        check("abort tx_ready", int'(tx_ready), 1);
        check("abort busy", int'(busy), 0);
        repeat (2000) @(negedge clk);
        check("abort no frame_done", done_cnt, 0);
        check("abort stays idle", int'(busy), 0);

        // Reset wins over a simultaneous accept
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h11;
        @(negedge clk);
        rst = 1'b0; tx_valid = 1'b0;
        check("reset-priority busy", int'(busy), 0);
        check("reset-priority tx_out", int'(tx_out), 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the bit-period count read from the bit-timing ROM.
REQ-002 CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 tx_data  input  8  byte to transmit; sampled only on the accept edge.
REQ-005 tx_valid  input  1  tx_data is valid.
REQ-006 tx_ready  output  1  block can accept a byte; high only in IDLE.
REQ-007 rom_addr  output  4  bit index 0..9 presented to the bit-timing ROM.
REQ-008 rom_data  input  WIDTH  bit period in CLOCK cycles; registered ROM, valid one cycle after rom_addr is sampled.
REQ-009 tx_out  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-012 Frame format: index 0 is the start bit (0), indices 1..8 are data bits LSB first, index 9 is the stop bit (1).
REQ-013 States: IDLE, ADDR, FETCH, BIT; held in a register.
REQ-014 Accept: tx_valid=1 and tx_ready=1 at an edge latches tx_data into the shift register, sets bit_idx=0 and tx_out=0, and moves to ADDR.
REQ-015 tx_valid while busy is ignored; no queuing; tx_data is not sampled outside accept.
REQ-016 rom_addr shall equal bit_idx and stay stable throughout ADDR, FETCH and BIT.
REQ-017 ADDR lasts 1 cycle, then goes to FETCH, giving the ROM its sampling edge.
REQ-018 FETCH lasts 1 cycle; at its ending edge cnt <= max(rom_data,3) - 3 (WIDTH-bit arithmetic), then go to BIT.
REQ-019 BIT: if cnt != 0, decrement cnt; if cnt == 0 the bit ends at that edge.
REQ-020 Bit duration is exactly max(rom_data,3) cycles, counted from the edge tx_out takes the bit value (ADDR + FETCH + BIT cycles).
REQ-021 Bit end with bit_idx < 9: bit_idx++, tx_out <= value of the new index (data bits from the shift register, LSB first; stop = 1), go to ADDR.
REQ-022 Bit end with bit_idx = 9: tx_out stays 1, go to IDLE; frame_done=1 during that last BIT cycle.
REQ-023 tx_ready is combinational from state (IDLE), so a new byte can be accepted on the first IDLE cycle after a frame.
REQ-024 rom_data values 0..2 are clamped to 3 and must not underflow cnt.
REQ-025 tx_out shall be glitch-free: driven only from a register.

Reset
REQ-026 When RESET=1 at an edge: state=IDLE, tx_out=1, bit_idx=0, cnt=0, shift register=0, frame_done=0.
REQ-027 Outputs after reset: tx_ready=1, busy=0, rom_addr=0.
REQ-028 RESET mid-frame aborts the frame immediately; line high from the next cycle; no frame_done.
REQ-029 RESET has priority over accept in the same cycle.

Verification
REQ-030 With a ROM giving 168 + bitmask (mask 0x3DF: index 5 = 168, others 169), send 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1. Durations 169 x5, 168, 169 x4. Frame = 1689 cycles. frame_done pulses once.
REQ-031 Hold tx_valid=1 with 0x00 then 0xFF -> second start bit begins on the edge after the first frame's IDLE entry, 1 cycle after frame_done; no extra stop time.
REQ-032 Pulse tx_valid with 0x3C while busy mid-frame -> ignored; the line carries only the original byte, and tx_ready=0 throughout.
REQ-033 Assert RESET at cycle 500 of a frame -> tx_out=1, tx_ready=1, busy=0 from the next cycle; no frame_done.
REQ-034 ROM returns 0 for all indices -> every bit lasts 3 cycles; frame = 30 cycles.
